// File: rtl/ip_tx_pkg.sv
// Shared IP transmit definitions: framer state encoding, IPv4 header constants
// and the header byte selector used by the framer.
package ip_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHKSUM,
        S_WAIT_ACK,
        S_HEADER,
        S_PAYLOAD,
        S_DONE
    } ip_tx_state_t;

    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [15:0] IP_FLAGS      = 16'h4000;
    localparam logic [15:0] IP_HDR_LEN    = 16'd20;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [7:0]  IP_PROTO_ICMP = 8'h01;

    // Byte idx (0..19) of the IPv4 header, most significant byte of each field first.
    function automatic logic [7:0] ip_hdr_byte(
        input logic [4:0]  idx,
        input logic [15:0] len,
        input logic [15:0] id,
        input logic [7:0]  ttl,
        input logic [7:0]  proto,
        input logic [15:0] csum,
        input logic [31:0] src,
        input logic [31:0] dst
    );
        logic [7:0] b;
        case (idx)
            5'd0:    b = IP_VER_IHL;
            5'd1:    b = 8'h00;
            5'd2:    b = len[15:8];
            5'd3:    b = len[7:0];
            5'd4:    b = id[15:8];
            5'd5:    b = id[7:0];
            5'd6:    b = IP_FLAGS[15:8];
            5'd7:    b = IP_FLAGS[7:0];
            5'd8:    b = ttl;
            5'd9:    b = proto;
            5'd10:   b = csum[15:8];
            5'd11:   b = csum[7:0];
            5'd12:   b = src[31:24];
            5'd13:   b = src[23:16];
            5'd14:   b = src[15:8];
            5'd15:   b = src[7:0];
            5'd16:   b = dst[31:24];
            5'd17:   b = dst[23:16];
            5'd18:   b = dst[15:8];
            5'd19:   b = dst[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ip_checksum_calc.sv
// IPv4 header checksum: sum of the nine header words, two carry folds, invert.
// Inputs must be held stable from start until done.
module ip_checksum_calc
    import ip_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [15:0] id,
    input  logic [15:0] ttl_proto,
    input  logic [31:0] src,
    input  logic [31:0] dst,
    output logic [15:0] csum,
    output logic        done
);

    logic [31:0] acc;
    logic [1:0]  phase;
    logic [31:0] sum9;
    logic [31:0] fold;

    assign sum9 = 32'({IP_VER_IHL, 8'h00}) + 32'(len) + 32'(id) + 32'(IP_FLAGS)
                + 32'(ttl_proto) + 32'(src[31:16]) + 32'(src[15:0])
                + 32'(dst[31:16]) + 32'(dst[15:0]);
    assign fold = 32'(acc[31:16]) + 32'(acc[15:0]);

    // Accumulate, fold, then fold-and-invert; done pulses with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            phase <= 2'd0;
            csum  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                2'd0: begin
                    if (start) begin
                        acc   <= sum9;
                        phase <= 2'd1;
                    end
                end
                2'd1: begin
                    acc   <= fold;
                    phase <= 2'd2;
                end
                2'd2: begin
                    csum  <= ~fold[15:0];
                    done  <= 1'b1;
                    phase <= 2'd0;
                end
                default: phase <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/ip_tx_framer.sv
// IPv4 transmit framer: latches a request, builds the 20-byte header and
// streams header plus payload to the MAC one byte per clock.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  S_IDLE     | waiting for ip_tx_ready; length checked on accept
//  S_CHKSUM   | header checksum being computed
//  S_WAIT_ACK | mac_tx_ready high, waiting for mac_tx_ack or timeout
//  S_HEADER   | loading header bytes 1..19 into the output register
//  S_PAYLOAD  | loading payload bytes 20..len-1 from ip_tx_data
//  S_DONE     | packet finished or aborted; waiting for ip_tx_ready low
//
// cnt is the index of the byte loaded at the next edge, so the output register
// shows byte cnt-1. Payload requests lead the load of their byte by PAYLOAD_LAT.
module ip_tx_framer
    import ip_tx_pkg::*;
#(
    parameter logic [7:0]  TTL         = 8'h80,
    parameter int          PAYLOAD_LAT = 2,
    parameter logic [15:0] MAX_LEN     = 16'd1500,
    parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ip_tx_ready,
    input  logic [7:0]  ip_send_type,
    input  logic [15:0] ip_send_data_length,
    input  logic [7:0]  ip_tx_data,
    input  logic [31:0] src_ip_addr,
    input  logic [31:0] dst_ip_addr,
    output logic        ip_tx_data_req,
    output logic        mac_tx_ready,
    input  logic        mac_tx_ack,
    output logic [15:0] mac_send_data_length,
    output logic        mac_tx_valid,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_last,
    output logic        ip_tx_err
);

    localparam logic [15:0] LAT16 = 16'(PAYLOAD_LAT);

    ip_tx_state_t state, state_nxt;

    logic [7:0]  proto_q;
    logic [15:0] len_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] id_q;
    logic [15:0] cnt;
    logic [15:0] timer;
    logic        cs_start;
    logic        cs_done;
    logic [15:0] cs_val;

    logic        accept;
    logic        bad_len;
    logic        load;
    logic        abort;
    logic        last_byte;

    ip_checksum_calc u_csum (
        .clk       (clk),
        .rst       (rst),
        .start     (cs_start),
        .len       (len_q),
        .id        (id_q),
        .ttl_proto ({TTL, proto_q}),
        .src       (src_q),
        .dst       (dst_q),
        .csum      (cs_val),
        .done      (cs_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state, byte-load strobes and the state-decoded outputs.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        bad_len        = 1'b0;
        load           = 1'b0;
        abort          = 1'b0;
        last_byte      = (cnt == len_q - 16'd1);
        mac_tx_ready   = (state == S_WAIT_ACK);
        ip_tx_data_req = ((state == S_HEADER) || (state == S_PAYLOAD))
                       && (cnt + LAT16 >= IP_HDR_LEN) && (cnt + LAT16 < len_q);
        unique case (state)
            S_IDLE: begin
                if (ip_tx_ready) begin
                    accept = 1'b1;
                    if ((ip_send_data_length < IP_HDR_LEN) || (ip_send_data_length > MAX_LEN)) begin
                        bad_len   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_CHKSUM;
                    end
                end
            end
            S_CHKSUM: begin
                if (cs_done) state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (mac_tx_ack) begin
                    load      = 1'b1;
                    state_nxt = S_HEADER;
                end else if (timer == 16'd1) begin
                    abort     = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_HEADER, S_PAYLOAD: begin
                load = 1'b1;
                if (last_byte)                          state_nxt = S_DONE;
                else if (cnt == IP_HDR_LEN - 16'd1)     state_nxt = S_PAYLOAD;
            end
            S_DONE: begin
                if (!ip_tx_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, ack timer, byte counter, identification and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_q      <= '0;
            len_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            id_q         <= '0;
            cnt          <= '0;
            timer        <= '0;
            cs_start     <= 1'b0;
            mac_tx_valid <= 1'b0;
            mac_tx_data  <= '0;
            mac_tx_last  <= 1'b0;
            ip_tx_err    <= 1'b0;
        end else begin
            cs_start  <= 1'b0;
            ip_tx_err <= bad_len | abort;
            if (accept) begin
                proto_q  <= ip_send_type;
                len_q    <= ip_send_data_length;
                src_q    <= src_ip_addr;
                dst_q    <= dst_ip_addr;
                cnt      <= '0;
                cs_start <= ~bad_len;
            end
            if (cs_done)                  timer <= ACK_TIMEOUT;
            else if (state == S_WAIT_ACK) timer <= timer - 16'd1;
            mac_tx_valid <= load;
            mac_tx_last  <= load & last_byte;
            if (load) begin
                cnt         <= cnt + 16'd1;
                mac_tx_data <= (cnt < IP_HDR_LEN)
                             ? ip_hdr_byte(cnt[4:0], len_q, id_q, TTL, proto_q, cs_val, src_q, dst_q)
                             : ip_tx_data;
                if (last_byte) id_q <= id_q + 16'd1;
            end else begin
                mac_tx_data <= '0;
            end
        end
    end

    assign mac_send_data_length = len_q;

endmodule

// File: tb/tb_ip_tx_framer.sv
// Directed bench for ip_tx_framer: normal UDP/ICMP packets, ack timeout,
// length bounds, held request and mid-packet reset.
module tb_ip_tx_framer;
    import ip_tx_pkg::*;

    localparam logic [15:0] TB_ACK_TO = 16'd40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ip_tx_ready = 1'b0;
    logic [7:0]  ip_send_type = '0;
    logic [15:0] ip_send_data_length = '0;
    logic [7:0]  ip_tx_data = '0;
    logic [31:0] src_ip_addr = 32'hC0A80102;
    logic [31:0] dst_ip_addr = 32'hC0A80103;
    logic        ip_tx_data_req;
    logic        mac_tx_ready;
    logic        mac_tx_ack = 1'b0;
    logic [15:0] mac_send_data_length;
    logic        mac_tx_valid;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_last;
    logic        ip_tx_err;

    ip_tx_framer #(.ACK_TIMEOUT(TB_ACK_TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ip_tx_ready          (ip_tx_ready),
        .ip_send_type         (ip_send_type),
        .ip_send_data_length  (ip_send_data_length),
        .ip_tx_data           (ip_tx_data),
        .src_ip_addr          (src_ip_addr),
        .dst_ip_addr          (dst_ip_addr),
        .ip_tx_data_req       (ip_tx_data_req),
        .mac_tx_ready         (mac_tx_ready),
        .mac_tx_ack           (mac_tx_ack),
        .mac_send_data_length (mac_send_data_length),
        .mac_tx_valid         (mac_tx_valid),
        .mac_tx_data          (mac_tx_data),
        .mac_tx_last          (mac_tx_last),
        .ip_tx_err            (ip_tx_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_d[$];
    logic       cap_l[$];
    int         req_n, rdy_n, err_n, pay_k;
    logic [7:0] pipe0 = '0;
    logic [7:0] pipe1 = '0;

    logic [7:0] hdr1 [20] = '{8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h80, 8'h11,
                              8'h77, 8'h69, 8'hC0, 8'hA8, 8'h01, 8'h02, 8'hC0, 8'hA8, 8'h01, 8'h03};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cap_at(input int i);
        if (i < cap_d.size()) return cap_d[i];
        return 8'hxx;
    endfunction

    function automatic logic cap_last_at(input int i);
        if (i < cap_l.size()) return cap_l[i];
        return 1'bx;
    endfunction

    // One clock: sample outputs after the edge, then play the upstream payload source
    // (byte for request k appears two cycles after the request, value k*3+5).
    task automatic cyc();
        @(posedge clk);
        #2;
        if (mac_tx_valid) begin
            cap_d.push_back(mac_tx_data);
            cap_l.push_back(mac_tx_last);
        end
        if (ip_tx_data_req) req_n++;
        if (mac_tx_ready)   rdy_n++;
        if (ip_tx_err)      err_n++;
        ip_tx_data = pipe1;
        pipe1      = pipe0;
        if (ip_tx_data_req) begin
            pipe0 = 8'(pay_k * 3 + 5);
            pay_k++;
        end else begin
            pipe0 = 8'h00;
        end
    endtask

    task automatic clear_mon();
        cap_d.delete();
        cap_l.delete();
        req_n = 0;
        rdy_n = 0;
        err_n = 0;
        pay_k = 0;
    endtask

    task automatic set_req(input logic [7:0] t, input logic [15:0] l);
        ip_send_type        = t;
        ip_send_data_length = l;
        ip_tx_ready         = 1'b1;
    endtask

    task automatic wait_ready_and_ack();
        int n = 0;
        while (!mac_tx_ready && n < 100) begin
            cyc();
            n++;
        end
        chk("mac_tx_ready_seen", mac_tx_ready, 1);
        mac_tx_ack = 1'b1;
        cyc();
        mac_tx_ack = 1'b0;
    endtask

    task automatic do_packet();
        int n = 0;
        wait_ready_and_ack();
        while ((cap_d.size() == 0 || mac_tx_valid) && n < 3000) begin
            cyc();
            n++;
        end
        chk("stream_ended", mac_tx_valid, 0);
    endtask

    task automatic drop_ready();
        ip_tx_ready = 1'b0;
        repeat (3) cyc();
    endtask

    function automatic int count_last();
        int nl = 0;
        foreach (cap_l[i]) if (cap_l[i]) nl++;
        return nl;
    endfunction

    initial begin
        clear_mon();
        repeat (3) cyc();
        chk("rst_mac_tx_ready", mac_tx_ready, 0);
        chk("rst_mac_tx_valid", mac_tx_valid, 0);
        chk("rst_mac_tx_data", mac_tx_data, 0);
        chk("rst_mac_tx_last", mac_tx_last, 0);
        chk("rst_ip_tx_err", ip_tx_err, 0);
        chk("rst_ip_tx_data_req", ip_tx_data_req, 0);
        chk("rst_mac_send_len", mac_send_data_length, 0);
        rst = 1'b0;
        repeat (2) cyc();

        // UDP len 46, id 0
        clear_mon();
        set_req(IP_PROTO_UDP, 16'd46);
        do_packet();
        chk("p1_len", cap_d.size(), 46);
        for (int i = 0; i < 20; i++) chk($sformatf("p1_hdr[%0d]", i), cap_at(i), hdr1[i]);
        for (int i = 0; i < 26; i++) chk($sformatf("p1_pay[%0d]", i), cap_at(20 + i), 8'(i * 3 + 5));
        chk("p1_last_count", count_last(), 1);
        chk("p1_last_pos", cap_last_at(45), 1);
        chk("p1_req_cycles", req_n, 26);
        chk("p1_mac_send_len", mac_send_data_length, 16'd46);

        // request held high after completion: no second packet
        clear_mon();
        repeat (30) cyc();
        chk("hold_no_ready", rdy_n, 0);
        chk("hold_no_bytes", cap_d.size(), 0);
        drop_ready();

        // same packet again, id 1
        clear_mon();
        set_req(IP_PROTO_UDP, 16'd46);
        do_packet();
        drop_ready();
        chk("p2_len", cap_d.size(), 46);
        chk("p2_id_hi", cap_at(4), 8'h00);
        chk("p2_id_lo", cap_at(5), 8'h01);
        chk("p2_csum_hi", cap_at(10), 8'h77);
        chk("p2_csum_lo", cap_at(11), 8'h68);
        chk("p2_pay0", cap_at(20), 8'h05);

        // ICMP len 20, id 2: header only
        clear_mon();
        set_req(IP_PROTO_ICMP, 16'd20);
        do_packet();
        drop_ready();
        chk("icmp_len", cap_d.size(), 20);
        chk("icmp_len_lo", cap_at(3), 8'h14);
        chk("icmp_id_lo", cap_at(5), 8'h02);
        chk("icmp_proto", cap_at(9), 8'h01);
        chk("icmp_csum_hi", cap_at(10), 8'h77);
        chk("icmp_csum_lo", cap_at(11), 8'h91);
        chk("icmp_req_cycles", req_n, 0);
        chk("icmp_last_pos", cap_last_at(19), 1);
        chk("icmp_last_count", count_last(), 1);

        // ack timeout: len 46, then len 1500 (largest accepted length)
        for (int t = 0; t < 2; t++) begin
            int n = 0;
            clear_mon();
            set_req(IP_PROTO_UDP, (t == 0) ? 16'd46 : 16'd1500);
            while (err_n == 0 && n < 500) begin
                cyc();
                n++;
            end
            chk($sformatf("to%0d_err", t), err_n, 1);
            chk($sformatf("to%0d_ready_cycles", t), rdy_n, 32'(TB_ACK_TO));
            chk($sformatf("to%0d_state", t), 32'(dut.state), 32'(S_DONE));
            repeat (3) cyc();
            chk($sformatf("to%0d_single_pulse", t), err_n, 1);
            chk($sformatf("to%0d_no_bytes", t), cap_d.size(), 0);
            chk($sformatf("to%0d_ready_low", t), mac_tx_ready, 0);
            drop_ready();
        end

        // bad lengths
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            set_req(IP_PROTO_UDP, (t == 0) ? 16'd19 : 16'd1501);
            repeat (10) cyc();
            chk($sformatf("bad%0d_err", t), err_n, 1);
            chk($sformatf("bad%0d_no_ready", t), rdy_n, 0);
            chk($sformatf("bad%0d_no_bytes", t), cap_d.size(), 0);
            drop_ready();
        end

        // ICMP after aborts: id still 3
        clear_mon();
        set_req(IP_PROTO_ICMP, 16'd20);
        do_packet();
        drop_ready();
        chk("icmp3_id_lo", cap_at(5), 8'h03);
        chk("icmp3_csum_lo", cap_at(11), 8'h90);

        // reset in payload
        begin
            int n = 0;
            clear_mon();
            set_req(IP_PROTO_UDP, 16'd46);
            wait_ready_and_ack();
            while (cap_d.size() < 25 && n < 100) begin
                cyc();
                n++;
            end
            chk("pre_rst_streaming", mac_tx_valid, 1);
            rst = 1'b1;
            ip_tx_ready = 1'b0;
            #1;
            chk("mid_rst_valid", mac_tx_valid, 0);
            chk("mid_rst_data", mac_tx_data, 0);
            chk("mid_rst_last", mac_tx_last, 0);
            chk("mid_rst_req", ip_tx_data_req, 0);
            chk("mid_rst_ready", mac_tx_ready, 0);
            chk("mid_rst_err", ip_tx_err, 0);
            chk("mid_rst_send_len", mac_send_data_length, 0);
            repeat (2) cyc();
            rst = 1'b0;
            repeat (2) cyc();
        end

        // fresh packet after reset: id 0
        clear_mon();
        set_req(IP_PROTO_ICMP, 16'd20);
        do_packet();
        drop_ready();
        chk("post_rst_len", cap_d.size(), 20);
        chk("post_rst_id_lo", cap_at(5), 8'h00);
        chk("post_rst_csum_hi", cap_at(10), 8'h77);
        chk("post_rst_csum_lo", cap_at(11), 8'h93);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
